// File: rtl/shiftrows_stream_if.sv
// rtl/shiftrows_stream_if.sv - byte stream port bundle for shiftrows_stream
//
// Purpose: groups the input byte stream and output byte stream of the
//          ShiftRows engine so the core and its users share one declaration.
// Signals:
//   enable   master->slave  inbyte valid, accepted on every rising edge
//   inbyte   master->slave  state byte, column-major (k = 4*c + r)
//   inverse  master->slave  0 = ShiftRows, 1 = InvShiftRows
//                           (only when SHIFTROWS_INV_EN is defined)
//   outbyte  slave->master  shifted state byte, column-major
//   ready    slave->master  outbyte valid this cycle
//   last     slave->master  final byte of an output block
// Macro: SHIFTROWS_INV_EN adds the inverse signal.

interface shiftrows_stream_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic [WIDTH-1:0] inbyte;
`ifdef SHIFTROWS_INV_EN
   logic             inverse;
`endif
   logic [WIDTH-1:0] outbyte;
   logic             ready;
   logic             last;

`ifdef SHIFTROWS_INV_EN
   modport master (output enable, output inbyte, output inverse,
                   input outbyte, input ready, input last);
   modport slave  (input enable, input inbyte, input inverse,
                   output outbyte, output ready, output last);
`else
   modport master (output enable, output inbyte,
                   input outbyte, input ready, input last);
   modport slave  (input enable, input inbyte,
                   output outbyte, output ready, output last);
`endif
endinterface

// File: rtl/shiftrows_stream.sv
// rtl/shiftrows_stream.sv - streaming Rijndael ShiftRows with ping-pong banks
//
// Purpose: accepts a 4*NB byte state one byte per enable, stores it in one of
//          two banks, and drains the row-shifted state one byte per cycle from
//          the other bank while the next block fills.
// Parameters:
//   WIDTH  bits per state byte lane (default 8)
//   NB     state columns, 4, 6 or 8 (default 4)
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   s_if   shiftrows_stream_if slave: enable/inbyte[/inverse] in,
//          outbyte/ready/last out
// Macro: SHIFTROWS_INV_EN enables the inverse input and InvShiftRows mapping;
//        undefined builds forward ShiftRows only.

module shiftrows_stream #(
   parameter int WIDTH = 8,
   parameter int NB    = 4
) (
   input  logic               clock,
   input  logic               reset,
   shiftrows_stream_if.slave  s_if
);

   localparam int              B        = 4 * NB;
   localparam int              CW       = $clog2(B);
   localparam logic [CW-1:0]   LAST_IDX = CW'(B - 1);
   localparam logic [3:0]      NB4      = 4'(NB);

   generate
      if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
         $error("shiftrows_stream: NB must be 4, 6 or 8");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   logic [WIDTH-1:0] r_bank [0:1][0:B-1];
   logic [CW-1:0]    r_wr_cnt;
   logic             r_wr_bank;
   logic [CW-1:0]    r_rd_cnt;
   logic             r_rd_bank;
   state_t           r_state;
`ifdef SHIFTROWS_INV_EN
   logic [1:0]       r_bank_inv;
`endif

   state_t           w_state_nxt;
   logic [CW-1:0]    w_rd_cnt_nxt;
   logic             w_rd_bank_nxt;
   logic             w_blk_done;
   logic [3:0]       w_col;
   logic [1:0]       w_row;
   logic [3:0]       w_shift;
   logic [3:0]       w_sum;
   logic [3:0]       w_src_col;
   logic [CW-1:0]    w_src_idx;
   logic             w_ready;

   assign w_blk_done = s_if.enable && (r_wr_cnt == LAST_IDX);

   // Fill side: counter wraps at B-1 and hands the bank over to the drain side.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (s_if.enable) begin
         if (r_wr_cnt == LAST_IDX) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
         end
      end
   end

   // Bank storage needs no reset; a discarded block is never read because the
   // drain side only starts on a completed fill.
   always_ff @(posedge clock) begin
      if (!reset && s_if.enable) begin
         r_bank[r_wr_bank][r_wr_cnt] <= s_if.inbyte;
`ifdef SHIFTROWS_INV_EN
         // Mode is latched with byte 0 and travels with the bank.
         if (r_wr_cnt == '0) begin
            r_bank_inv[r_wr_bank] <= s_if.inverse;
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_cnt  <= w_rd_cnt_nxt;
         r_rd_bank <= w_rd_bank_nxt;
      end
   end

   // A fill cannot complete mid-drain: the next block needs B accepted bytes,
   // so at full rate its completion lands exactly on the final drain byte.
   always_comb begin
      w_state_nxt   = r_state;
      w_rd_cnt_nxt  = r_rd_cnt;
      w_rd_bank_nxt = r_rd_bank;
      case (r_state)
         ST_IDLE: begin
            if (w_blk_done) begin
               w_state_nxt   = ST_DRAIN;
               w_rd_cnt_nxt  = '0;
               w_rd_bank_nxt = r_wr_bank;
            end
         end
         ST_DRAIN: begin
            if (r_rd_cnt == LAST_IDX) begin
               w_rd_cnt_nxt = '0;
               if (w_blk_done) begin
                  w_rd_bank_nxt = r_wr_bank;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_rd_cnt_nxt = r_rd_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_rd_cnt_nxt = '0;
         end
      endcase
   end

   // Source column for the byte being emitted; one conditional subtract keeps
   // the column in 0..NB-1 for both shift directions.
   always_comb begin
      w_col = 4'(r_rd_cnt >> 2);
      w_row = r_rd_cnt[1:0];
      case (w_row)
         2'd0:    w_shift = 4'd0;
         2'd1:    w_shift = 4'd1;
         2'd2:    w_shift = (NB == 8) ? 4'd3 : 4'd2;
         default: w_shift = (NB == 8) ? 4'd4 : 4'd3;
      endcase
`ifdef SHIFTROWS_INV_EN
      if (r_bank_inv[r_rd_bank]) begin
         w_sum = w_col + NB4 - w_shift;
      end else begin
         w_sum = w_col + w_shift;
      end
`else
      w_sum = w_col + w_shift;
`endif
      w_src_col = (w_sum >= NB4) ? (w_sum - NB4) : w_sum;
      w_src_idx = CW'({w_src_col, w_row});
   end

   assign w_ready      = (r_state == ST_DRAIN);
   assign s_if.ready   = w_ready;
   assign s_if.last    = w_ready && (r_rd_cnt == LAST_IDX);
   assign s_if.outbyte = w_ready ? r_bank[r_rd_bank][w_src_idx] : '0;

endmodule
